// File: rtl/str_pkg.sv
// str_pkg: shared stream constants and pointer-width helper
package str_pkg;
  localparam int STR_VW_DEFAULT = 32;
  function automatic int str_aw(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/str_fifo_mem.sv
// str_fifo_mem: DEPTH x VW register file, synchronous write, asynchronous read, no reset
module str_fifo_mem import str_pkg::*; #(
  parameter int VW = STR_VW_DEFAULT,
  parameter int DEPTH = 8,
  localparam int AW = str_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [VW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [VW-1:0] rdata
);
  logic [VW-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/str_fifo.sv
// str_fifo: elastic tvalid/tready stream buffer; STR_FIFO_WATERMARK_EN adds the afull output
module str_fifo import str_pkg::*; #(
  parameter int VW = STR_VW_DEFAULT,
  parameter int DEPTH = 8,
`ifdef STR_FIFO_WATERMARK_EN
  parameter int AFULL = DEPTH - 2,
`endif
  localparam int AW = str_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          s_tvalid,
  output logic          s_tready,
  input  logic [VW-1:0] s_tvalue,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [VW-1:0] m_tvalue,
`ifdef STR_FIFO_WATERMARK_EN
  output logic          afull,
`endif
  output logic [AW:0]   count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [AW:0] wp, rp, count_next;
  logic wr, rd;
  assign wr = s_tvalid & s_tready;
  assign rd = m_tvalid & m_tready;
  assign count_next = count + (AW+1)'(wr) - (AW+1)'(rd);
  // flags are registered from the next-state count, so no ready/valid combinational path exists
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      s_tready <= 1'b0;
      m_tvalid <= 1'b0;
`ifdef STR_FIFO_WATERMARK_EN
      afull <= 1'b0;
`endif
    end else begin
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(rd);
      count <= count_next;
      s_tready <= count_next != FULL;
      m_tvalid <= count_next != '0;
`ifdef STR_FIFO_WATERMARK_EN
      afull <= count_next >= (AW+1)'(AFULL);
`endif
    end
  end
  str_fifo_mem #(.VW(VW), .DEPTH(DEPTH)) u_mem (
    .clk(clk),
    .we(wr),
    .waddr(wp[AW-1:0]),
    .wdata(s_tvalue),
    .raddr(rp[AW-1:0]),
    .rdata(m_tvalue)
  );
endmodule

// File: tb/tb_str_fifo.sv
// tb_str_fifo: directed and random stimulus against a queue model of the stream buffer
module tb_str_fifo;
  localparam int VW = 8;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, s_tvalid, s_tready, m_tvalid, m_tready;
  logic [VW-1:0] s_tvalue, m_tvalue;
  logic [2:0] count;
`ifdef STR_FIFO_WATERMARK_EN
  logic afull;
`endif
  int checks = 0;
  int failures = 0;
  logic [VW-1:0] q[$];
  logic exp_rdy = 1'b0;

  str_fifo #(
    .VW(VW),
`ifdef STR_FIFO_WATERMARK_EN
    .AFULL(3),
`endif
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tvalue(s_tvalue),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tvalue(m_tvalue),
`ifdef STR_FIFO_WATERMARK_EN
    .afull(afull),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("count", 32'(count), 32'(q.size()));
    chk("m_tvalid", 32'(m_tvalid), 32'(q.size() != 0));
    chk("s_tready", 32'(s_tready), 32'(exp_rdy));
    if (q.size() != 0) chk("m_tvalue", 32'(m_tvalue), 32'(q[0]));
`ifdef STR_FIFO_WATERMARK_EN
    chk("afull", 32'(afull), 32'(rst && q.size() >= 3));
`endif
  endtask

  task automatic step(input logic r, input logic sv, input logic [VW-1:0] d, input logic mr);
    rst = r;
    s_tvalid = sv;
    s_tvalue = d;
    m_tready = mr;
    @(posedge clk);
    if (!r) begin
      q.delete();
      exp_rdy = 1'b0;
    end else begin
      if (mr && q.size() != 0) void'(q.pop_front());
      if (sv && exp_rdy) q.push_back(d);
      exp_rdy = q.size() != DEPTH;
    end
    #1 check_outputs();
  endtask

  initial begin
    rst = 1'b0; s_tvalid = 1'b0; s_tvalue = '0; m_tready = 1'b0;
    #1;
    step(0, 0, 8'h00, 0);
    step(0, 1, 8'h11, 1);
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'hA5, 1);
    step(1, 0, 8'h00, 1);
    for (int i = 1; i <= 5; i++) step(1, 1, 8'(i), 0);
    step(1, 1, 8'h05, 0);
    step(1, 1, 8'h05, 1);
    step(1, 1, 8'h05, 1);
    repeat (6) step(1, 0, 8'h00, 1);
    for (int i = 0; i < 20; i++) step(1, 1, 8'(8'h10 + i), 1);
    step(1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h60 + i), 0);
    step(0, 1, 8'h99, 0);
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h7E, 1);
    step(1, 0, 8'h00, 1);
    for (int i = 0; i < 3; i++) step(1, 1, 8'(8'hC0 + i), 0);
    step(1, 0, 8'h00, 1);
    repeat (3) step(1, 0, 8'h00, 1);
    for (int i = 0; i < 500; i++)
      step(($urandom_range(63) != 0), 1'($urandom_range(3) != 0), 8'($urandom), 1'($urandom_range(2) != 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
